// File: rtl/reg_bank_arbiter.sv
// Shared flip-flop register bank behind a round-robin arbiter.
// One access (read or write) is granted per cycle. The grant is combinational
// and read data returns one cycle after the grant, tagged by a one-hot rvalid.
module reg_bank_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*AW-1:0]     addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [15:0]               grant_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Grant counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Pointer moves to the requester just after the winner, modulo NUM_REQ.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] k);
        if (int'(k) == NUM_REQ - 1)
            return '0;
        else
            return k + 1'b1;
    endfunction

    logic [DATA_W-1:0] bank [DEPTH];
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [PW-1:0]     idx_w;
    logic              any_gnt;
    int                idx;

    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [DATA_W-1:0]  rdata_p1;
    logic [NUM_REQ-1:0] vld_p1;
    logic [15:0]        cnt_q;

    // Round-robin search starting at rr_ptr; the first requester found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        idx_w   = '0;
        if (!rst) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                idx   = (int'(rr_ptr) + j) % NUM_REQ;
                idx_w = PW'(idx);
                if (!any_gnt && req[idx_w]) begin
                    any_gnt     = 1'b1;
                    gnt[idx_w]  = 1'b1;
                    gnt_idx     = idx_w;
                end
            end
        end
    end

    // Mux the winning requester's access fields onto the bank port.
    always_comb begin
        sel_we    = we[gnt_idx];
        sel_addr  = addr[gnt_idx*AW +: AW];
        sel_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
    end

    // Register bank: cleared by reset, written by a granted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                bank[i] <= '0;
        end else if (any_gnt && sel_we) begin
            bank[sel_addr] <= sel_wdata;
        end
    end

    // Arbiter pointer and saturating grant counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else if (any_gnt) begin
            rr_ptr <= ptr_next(gnt_idx);
            cnt_q  <= sat_inc(cnt_q);
        end
    end

    // ---- stage p1: registered read data and its owner tag ----
    // Read port: rdata captures pre-edge bank contents; rvalid pulses per read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            vld_p1   <= '0;
        end else begin
            if (any_gnt && !sel_we) begin
                rdata_p1 <= bank[sel_addr];
                vld_p1   <= gnt;
            end else begin
                vld_p1   <= '0;
            end
        end
    end

    assign rdata     = rdata_p1;
    assign rvalid    = vld_p1;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: stimulus pushes expected read
// responses into a queue and a monitor pops them whenever rvalid is seen.
module tb_reg_bank_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     we;
    logic [N*AW-1:0]  addr;
    logic [N*DW-1:0]  wdata;
    logic [N-1:0]     gnt;
    logic [DW-1:0]    rdata;
    logic [N-1:0]     rvalid;
    logic [15:0]      grant_cnt;

    reg_bank_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .grant_cnt(grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [11:0]  exp_q [$];
    logic [7:0]   mbank [16];
    int           mptr;
    int           mcnt;
    logic [N-1:0] gseen;

    logic [N-1:0] hold;
    logic [N-1:0] hreq, hwe;
    logic [3:0]   ha [N];
    logic [7:0]   hd [N];
    int           waitc [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            int ix;
            ix = (p + j) % N;
            if (r[ix]) return N'(1) << ix;
        end
        return '0;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    // One arbitration cycle: drive at negedge, check gnt, push expected read.
    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] w,
                        input logic [15:0] a, input logic [31:0] d,
                        input logic [N-1:0] exp_g, input logic [7:0] exp_rd,
                        input string name);
        int k;
        req = rq; we = w; addr = a; wdata = d;
        #1;
        chk(name, 32'(gnt), 32'(exp_g));
        gseen = gnt;
        if (exp_g != 0) begin
            k = oh2idx(exp_g);
            if (!w[k]) exp_q.push_back({exp_g, exp_rd});
            else mbank[a[k*AW +: AW]] = d[k*DW +: DW];
            mptr = (k + 1) % N;
            if (mcnt < 65535) mcnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset cycle with a request pattern applied; gnt must stay low.
    task automatic rst_step(input logic [N-1:0] rq, input logic [N-1:0] w,
                            input logic [15:0] a, input logic [31:0] d);
        rst = 1'b1; req = rq; we = w; addr = a; wdata = d;
        #1;
        chk("gnt_in_reset", 32'(gnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
        mptr = 0;
        mcnt = 0;
    endtask

    // Monitor: every rvalid must match the oldest outstanding expected read.
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid != 0) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rvalid: got rvalid=%b rdata=%h, none expected", rvalid, rdata);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(e[11:8]));
                    chk("rdata", 32'(rdata), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        mptr = 0; mcnt = 0; hold = '0; hreq = '0; hwe = '0;
        for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
        for (int i = 0; i < N; i++) begin waitc[i] = 0; ha[i] = '0; hd[i] = '0; end

        // Reset held two cycles with all requesting.
        rst_step(4'b1111, 4'b0000, 16'h0, 32'h0);
        rst_step(4'b1111, 4'b1111, 16'hFFFF, 32'hFFFFFFFF);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        for (int i = 0; i < 16; i++)
            step(4'b0001, 4'b0000, 16'(i), 32'h0, 4'b0001, 8'h00, "rst_read_all");

        // Requester 2 writes A5 to addr 3, then reads it back.
        step(4'b0100, 4'b0100, 16'h0300, 32'h00A50000, 4'b0100, 8'h00, "r2_write");
        step(4'b0100, 4'b0000, 16'h0300, 32'h0, 4'b0100, 8'hA5, "r2_read");

        // Round robin from reset, all four reading.
        rst_step(4'b0000, 4'b0000, 16'h0, 32'h0);
        for (int c = 0; c < 8; c++)
            step(4'b1111, 4'b0000, 16'h3210, 32'h0, 4'(1 << (c % 4)), 8'h00, "rr_seq");
        chk("rr_grant_cnt", 32'(grant_cnt), 32'd8);

        // Pointer skip.
        step(4'b0001, 4'b0000, 16'h0, 32'h0, 4'b0001, 8'h00, "skip_g0");
        step(4'b1001, 4'b0000, 16'h0, 32'h0, 4'b1000, 8'h00, "skip_g3");
        step(4'b1001, 4'b0000, 16'h0, 32'h0, 4'b0001, 8'h00, "skip_g0b");
        for (int c = 0; c < 3; c++)
            step(4'b0100, 4'b0000, 16'h0, 32'h0, 4'b0100, 8'h00, "lone_r2");

        // Read-after-write across requesters, then reset over a write.
        step(4'b0010, 4'b0010, 16'h00F0, 32'h00003C00, 4'b0010, 8'h00, "raw_write");
        step(4'b1000, 4'b0000, 16'hF000, 32'h0, 4'b1000, 8'h3C, "raw_read");
        rst_step(4'b0001, 4'b0001, 16'h0000, 32'h000000FF);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_grant_cnt", 32'(grant_cnt), 32'd0);
        step(4'b0001, 4'b0000, 16'h0000, 32'h0, 4'b0001, 8'h00, "post_rst_a0");
        step(4'b0001, 4'b0000, 16'h000F, 32'h0, 4'b0001, 8'h00, "post_rst_a15");

        // Randomized traffic with held requests until granted.
        for (int c = 0; c < 500; c++) begin
            logic [N-1:0] rq, w, eg;
            logic [15:0]  a;
            logic [31:0]  d;
            logic [7:0]   erd;
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    hreq[i] = 1'($urandom_range(0, 1));
                    hwe[i]  = 1'($urandom_range(0, 1));
                    ha[i]   = 4'($urandom_range(0, 15));
                    hd[i]   = 8'($urandom_range(0, 255));
                end
            end
            rq = hreq; w = hwe;
            for (int i = 0; i < N; i++) begin
                a[i*AW +: AW] = ha[i];
                d[i*DW +: DW] = hd[i];
            end
            eg  = rr_pick(rq, mptr);
            erd = 8'h00;
            if (eg != 0) erd = mbank[a[oh2idx(eg)*AW +: AW]];
            step(rq, w, a, d, eg, erd, "rand_gnt");
            total++;
            if (!$onehot0(gseen)) begin
                bad++;
                $display("FAIL rand_onehot: got gnt=%b, required one-hot or zero", gseen);
            end
            for (int i = 0; i < N; i++) begin
                if (rq[i] && !gseen[i]) begin
                    waitc[i]++;
                    total++;
                    if (waitc[i] > N - 1) begin
                        bad++;
                        $display("FAIL rand_wait: requester %0d waited %0d cycles, max %0d", i, waitc[i], N - 1);
                    end
                    hold[i] = 1'b1;
                end else begin
                    waitc[i] = 0;
                    hold[i]  = 1'b0;
                    hreq[i]  = 1'b0;
                end
            end
        end

        step(4'b0000, 4'b0000, 16'h0, 32'h0, 4'b0000, 8'h00, "idle");
        step(4'b0000, 4'b0000, 16'h0, 32'h0, 4'b0000, 8'h00, "idle");
        chk("final_grant_cnt", 32'(grant_cnt), 32'(mcnt));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shared register bank of DEPTH words, each DATA_W bits wide, built from flip-flops.
- NUM_REQ requesters share the bank through a round-robin arbiter that grants one access (read or write) per cycle.
- Sits between the attention/MAC engines and the bank that holds their configuration and scale registers, so no engine needs private storage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, register word width in bits.
- DEPTH, 16, number of registers; must be a power of two.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester access request; held high until granted.
- we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read); valid while req is high.
- addr  input  NUM_REQ*AW  packed addresses; requester i uses slice [i*AW +: AW].
- wdata  input  NUM_REQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant; combinational, same cycle as req.
- rdata  output  DATA_W  registered read data.
- rvalid  output  NUM_REQ  one-hot, registered; marks which requester owns rdata.
- grant_cnt  output  16  registered count of total grants; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - all DEPTH registers = 0.
  - rr_ptr = 0.
  - rdata = 0, rvalid = 0, grant_cnt = 0.
  - rst overrides any write in the same cycle.
- gnt is 0 while rst is high.
- Arbitration (combinational):
  - Search req starting at index rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit gets gnt.
  - If req == 0, then gnt == 0.
  - gnt is never multi-hot.
- Pointer update:
  - On a clock edge with a grant to requester k, rr_ptr <= (k+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - Grants to different requesters therefore rotate; a lone requester is granted every cycle.
- Write: when gnt[k] and we[k], bank[addr_k] <= wdata_k at that edge. No write latency is visible to later reads.
- Read:
  - When gnt[k] and !we[k]: at that edge, rdata <= bank[addr_k] and rvalid <= one-hot(k). Latency is 1 cycle.
  - rdata reflects bank contents before the edge; a read cannot alias a write because only one access is granted per cycle.
  - In any cycle without a granted read, rvalid <= 0 and rdata holds its last value.
- Read-after-write: a write granted in cycle N followed by a read to the same address granted in cycle N+1 returns the new data in cycle N+2.
- Handshake:
  - A requester samples gnt in the same cycle it drives req.
  - It may drop req or present the next access on the following cycle.
  - An ungranted req must stay high with stable we/addr/wdata. Changing them before grant is permitted but unprotected; the arbiter uses whatever is present in the granting cycle.
- grant_cnt increments by 1 on every edge with any gnt bit set; it saturates and does not wrap.
- Reset mid-operation: a pending read's rvalid is suppressed, and no partial write occurs.
- The address range is always legal (DEPTH is a power of two), so there is no error path.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with req=4'b1111 -> gnt=0, rvalid=0, rdata=0, grant_cnt=0; then a read of every address returns 8'h00.
- Single-requester write/read: requester 2 writes 8'hA5 to addr 3, then reads addr 3 -> gnt=4'b0100 on both cycles; one cycle after the read, rdata=8'hA5 and rvalid=4'b0100.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held for 8 cycles, all reads, starting from reset.
  - gnt sequence: 0001, 0010, 0100, 1000, repeating.
  - grant_cnt=8 afterwards.
  - rvalid follows gnt with a 1-cycle lag.
- Pointer skip:
  - Stimulus: after a grant to requester 0, assert req=4'b1001.
  - Next gnt = 4'b1000, then 4'b0001.
  - With req=4'b0100 alone for 3 cycles, gnt=4'b0100 on every cycle.
- Read-after-write and sync reset:
  - Stimulus: requester 1 writes 8'h3C to addr 15; requester 3 reads addr 15 in the next cycle.
  - rdata=8'h3C in the following cycle.
  - Then assert rst=1 for one cycle while requester 0 is granted a write of 8'hFF to addr 0 -> rvalid=0, and reading addr 0 and addr 15 afterwards returns 8'h00.
- Randomized: 500 cycles of random req/we/addr/wdata against a reference model of the bank -> every rvalid cycle has rdata equal to the model value; gnt is always one-hot or zero; no requester with req held high waits more than NUM_REQ-1 cycles.
